// File: rtl/time_pkg.sv
// time_pkg: shared state encoding and default sizing for the clock-setting blocks
package time_pkg;
  typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} state_t;
  localparam int NUM_FIELDS_DEF    = 3;
  localparam int TIMEOUT_TICKS_DEF = 10;
endpackage

// File: rtl/field_select_fsm_if.sv
// field_select_fsm_if: button/tick inputs and field-enable outputs of the field sequencer
interface field_select_fsm_if #(parameter int NUM_FIELDS = 3);
  localparam int IDX_W = $clog2(NUM_FIELDS);
  logic                  sharp;
  logic                  back;
  logic                  tick;
  logic [NUM_FIELDS-1:0] field_en;
  logic [IDX_W-1:0]      field_idx;
  logic                  editing;
  logic                  done;
  logic                  timed_out;
  modport master (output sharp, back, tick, input field_en, field_idx, editing, done, timed_out);
  modport slave  (input sharp, back, tick, output field_en, field_idx, editing, done, timed_out);
endinterface

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on each rising edge of a synchronous level
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic in_d;
  always_ff @(posedge clock or negedge reset)
    if (!reset) in_d <= 1'b0;
    else        in_d <= in;
  assign pulse = in & ~in_d;
endmodule

// File: rtl/field_select_fsm.sv
// field_select_fsm: steps a one-hot edit enable across time fields with back-step and inactivity timeout
module field_select_fsm
  import time_pkg::*;
#(
  parameter int NUM_FIELDS    = NUM_FIELDS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input logic               clock,
  input logic               reset,
  field_select_fsm_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_FIELDS);
  localparam int CNT_W = TIMEOUT_TICKS > 0 ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [IDX_W-1:0]      LAST = IDX_W'(NUM_FIELDS - 1);
  localparam logic [NUM_FIELDS-1:0] ONE  = NUM_FIELDS'(1);
  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_FIELDS-1:0] en;
  logic                  editing_q, done_q, to_q;
  logic                  adv, bk, adv_only, bk_only;
  rise_detect u_sharp (.clock(clock), .reset(reset), .in(bus.sharp), .pulse(adv));
  rise_detect u_back  (.clock(clock), .reset(reset), .in(bus.back),  .pulse(bk));
  assign adv_only = adv & ~bk;
  assign bk_only  = bk & ~adv;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      en        <= '0;
      editing_q <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      to_q   <= 1'b0;
      // IDLE also scrubs any out-of-range index back to a clean idle
      if (state == IDLE || idx > LAST) begin
        cnt <= '0;
        if (state == IDLE && adv_only) begin
          state     <= EDIT;
          idx       <= '0;
          en        <= ONE;
          editing_q <= 1'b1;
        end else begin
          state     <= IDLE;
          idx       <= '0;
          en        <= '0;
          editing_q <= 1'b0;
        end
      end else if (adv | bk) begin
        cnt <= '0;
        if (adv_only && idx == LAST) begin
          state     <= IDLE;
          idx       <= '0;
          en        <= '0;
          editing_q <= 1'b0;
          done_q    <= 1'b1;
        end else if (adv_only) begin
          idx <= idx + 1'b1;
          en  <= ONE << (idx + 1'b1);
        end else if (bk_only && idx != '0) begin
          idx <= idx - 1'b1;
          en  <= ONE << (idx - 1'b1);
        end
      end else if (bus.tick && TIMEOUT_TICKS != 0) begin
        if (cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
          state     <= IDLE;
          idx       <= '0;
          en        <= '0;
          editing_q <= 1'b0;
          done_q    <= 1'b1;
          to_q      <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  assign bus.field_en  = en;
  assign bus.field_idx = idx;
  assign bus.editing   = editing_q;
  assign bus.done      = done_q;
  assign bus.timed_out = to_q;
endmodule

// File: tb/tb_field_select_fsm.sv
// tb_field_select_fsm: directed checks of the field sequencer in a 3-field/timeout-3 and a 5-field/no-timeout build
module tb_field_select_fsm;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  always #5 clock = ~clock;
  field_select_fsm_if #(.NUM_FIELDS(3)) ia ();
  field_select_fsm_if #(.NUM_FIELDS(5)) ib ();
  field_select_fsm #(.NUM_FIELDS(3), .TIMEOUT_TICKS(3)) ua (.clock(clock), .reset(reset), .bus(ia));
  field_select_fsm #(.NUM_FIELDS(5), .TIMEOUT_TICKS(0)) ub (.clock(clock), .reset(reset), .bus(ib));
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tap_a(input logic s, input logic b, input logic t);
    ia.sharp = s; ia.back = b; ia.tick = t;
    step();
    ia.sharp = 1'b0; ia.back = 1'b0; ia.tick = 1'b0;
    step();
  endtask
  task automatic tap_b_sharp();
    ib.sharp = 1'b1;
    step();
    ib.sharp = 1'b0;
    step();
  endtask
  initial begin
    logic seen;
    ia.sharp = 0; ia.back = 0; ia.tick = 0;
    ib.sharp = 0; ib.back = 0; ib.tick = 0;
    repeat (3) step();
    chk("rst_en", ia.field_en, 0);
    chk("rst_idx", ia.field_idx, 0);
    chk("rst_done", {ia.editing, ia.done, ia.timed_out}, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_hold", {ia.field_en, ia.field_idx, ia.editing}, 0);
    end
    // four held sharp presses walk 001,010,100 and exit
    for (int p = 0; p < 4; p++) begin
      ia.sharp = 1'b1;
      step();
      chk("adv_en", ia.field_en, p < 3 ? (32'd1 << p) : 32'd0);
      chk("adv_done", {ia.done, ia.timed_out}, p == 3 ? 2'b10 : 2'b00);
      step();
      chk("adv_hold", {ia.field_en, ia.done}, p < 3 ? ((32'd1 << p) << 1) : 32'd0);
      repeat (3) step();
      ia.sharp = 1'b0;
      step();
    end
    repeat (3) tap_a(1, 0, 0);
    chk("at_last", {ia.field_en, ia.field_idx}, {3'b100, 2'd2});
    tap_a(0, 1, 0);
    chk("back1", {ia.field_en, ia.field_idx}, {3'b010, 2'd1});
    tap_a(0, 1, 0);
    chk("back2", {ia.field_en, ia.field_idx}, {3'b001, 2'd0});
    tap_a(0, 1, 0);
    chk("back_sat", {ia.field_en, ia.field_idx, ia.editing}, {3'b001, 2'd0, 1'b1});
    repeat (3) tap_a(1, 0, 0);
    chk("exit_idle", ia.editing, 0);
    tap_a(0, 1, 0);
    chk("back_idle", {ia.field_en, ia.editing}, 0);
    // timeout after three quiet ticks
    tap_a(1, 0, 0);
    tap_a(0, 0, 1);
    tap_a(0, 0, 1);
    chk("pre_to", {ia.field_en, ia.done}, {3'b001, 1'b0});
    ia.tick = 1'b1;
    step();
    chk("to_fire", {ia.field_en, ia.editing, ia.done, ia.timed_out}, {3'b000, 3'b011});
    ia.tick = 1'b0;
    step();
    chk("to_pulse", {ia.done, ia.timed_out}, 0);
    tap_a(1, 0, 0);
    tap_a(0, 0, 1);
    tap_a(0, 0, 1);
    tap_a(1, 0, 0);
    tap_a(0, 0, 1);
    tap_a(0, 0, 1);
    chk("to_restart", {ia.field_en, ia.editing}, {3'b010, 1'b1});
    ia.tick = 1'b1;
    step();
    chk("to_late", {ia.editing, ia.done, ia.timed_out}, 3'b011);
    ia.tick = 1'b0;
    step();
    // simultaneous press is ignored but still resets the timeout
    tap_a(1, 0, 0);
    tap_a(1, 0, 0);
    tap_a(0, 0, 1);
    tap_a(0, 0, 1);
    tap_a(1, 1, 0);
    chk("both_idx", {ia.field_en, ia.field_idx}, {3'b010, 2'd1});
    tap_a(0, 0, 1);
    tap_a(0, 0, 1);
    chk("both_clr", {ia.editing, ia.field_idx}, {1'b1, 2'd1});
    ia.sharp = 1'b1; ia.tick = 1'b1;
    step();
    chk("press_tick", {ia.field_en, ia.done, ia.timed_out}, {3'b100, 2'b00});
    ia.sharp = 1'b0; ia.tick = 1'b0;
    step();
    tap_a(0, 0, 1);
    tap_a(0, 0, 1);
    chk("pt_clr", ia.editing, 1);
    ia.tick = 1'b1;
    step();
    chk("pt_to", {ia.done, ia.timed_out, ia.field_en}, {2'b11, 3'b000});
    ia.tick = 1'b0;
    step();
    // five-field build without timeout
    for (int p = 0; p < 6; p++) begin
      ib.sharp = 1'b1;
      step();
      chk("b_walk", {ib.field_en, ib.done}, p < 5 ? {5'd1 << p, 1'b0} : 6'b000001);
      ib.sharp = 1'b0;
      step();
    end
    tap_b_sharp();
    seen = 1'b0;
    ib.tick = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (ib.done || ib.timed_out) seen = 1'b1;
    end
    ib.tick = 1'b0;
    chk("b_no_to", {seen, ib.editing, ib.field_en}, {2'b01, 5'b00001});
    tap_b_sharp();
    tap_b_sharp();
    chk("b_idx2", {ib.field_en, ib.field_idx}, {5'b00100, 3'd2});
    reset = 1'b0;
    #1;
    chk("b_async", {ib.field_en, ib.field_idx, ib.editing, ib.done}, 0);
    step();
    reset = 1'b1;
    step();
    chk("b_after_rst", {ib.field_en, ib.editing, ib.done, ib.timed_out}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
